// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit types, classification constants and helpers
// Purpose: operand classes, scheduler state encoding and the accumulator tag
//          carried alongside the decoder pipeline.
// Ports:   none (package).
package posit_pkg;

    // Widest posit the helper functions accept; callers zero-extend into it.
    localparam int MAX_W = 32;

    localparam logic [1:0] VLD_ZERO  = 2'b00;
    localparam logic [1:0] VLD_VALID = 2'b01;
    localparam logic [1:0] VLD_NAR   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic slot;
        logic skip;
        logic first;
        logic last;
    } tag_t;

    // NaR is the single pattern with only the sign bit set.
    function automatic logic is_nar(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] m;
        m = MAX_W'(1) << (w - 1);
        return (x == m);
    endfunction

    // Operands are zero-extended, so upper bits never disturb the test.
    function automatic logic is_zero(input logic [MAX_W-1:0] x);
        return (x == '0);
    endfunction

    function automatic logic [1:0] classify(input logic [MAX_W-1:0] x, input int w);
        if (is_nar(x, w))
            return VLD_NAR;
        else if (is_zero(x))
            return VLD_ZERO;
        else
            return VLD_VALID;
    endfunction

endpackage

// File: rtl/posit_tag_pipe.sv
// rtl/posit_tag_pipe.sv - fixed-depth tag delay line with synchronous flush
// Purpose: delays accumulator tags so they line up with decoder outputs.
// Ports:   clk_i  clock
//          flush  synchronous clear of every stage
//          tag_i  tag entering the line
//          tag_o  tag leaving the line after DEPTH cycles
module posit_tag_pipe
    import posit_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic flush,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk_i) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++)
                r_stage[i] <= '0;
        end else begin
            r_stage[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++)
                r_stage[i] <= r_stage[i-1];
        end
    end

    assign tag_o = r_stage[DEPTH-1];

endmodule

// File: rtl/posit_decode_sched.sv
// rtl/posit_decode_sched.sv - dot-product job sequencer feeding a paired posit decoder
// Purpose: joins weight/activation streams, skips zero pairs, tracks NaR and
//          emits accumulator controls aligned with the decoder outputs.
// Ports:   clk_i, rst                      clock, sync active-high reset
//          start, len                      job request (sampled in IDLE)
//          s_w_valid/s_w_data              weight stream
//          s_d_valid/s_d_data, s_ready     activation stream, joint ready
//          dec_vld/dec_win/dec_din         decoder inputs
//          acc_en/acc_skip/acc_first/acc_last  accumulator controls
//          busy, done, nar                 job status
module posit_decode_sched
    import posit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int EXP     = 2,
    parameter int LEN_W   = 8,
    parameter int DEC_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             s_w_valid,
    input  logic [WIDTH-1:0] s_w_data,
    input  logic             s_d_valid,
    input  logic [WIDTH-1:0] s_d_data,
    output logic             s_ready,
    output logic             dec_vld,
    output logic [WIDTH-1:0] dec_win,
    output logic [WIDTH-1:0] dec_din,
    output logic             acc_en,
    output logic             acc_skip,
    output logic             acc_first,
    output logic             acc_last,
    output logic             busy,
    output logic             done,
    output logic             nar
);

    generate
        if (DEC_LAT < 1) begin : g_bad_lat
            $error("posit_decode_sched: DEC_LAT must be >= 1");
        end
        if (WIDTH < 3 || WIDTH > MAX_W || EXP < 0 || EXP > WIDTH - 3) begin : g_bad_fmt
            $error("posit_decode_sched: unsupported WIDTH/EXP combination");
        end
    endgenerate

    localparam int DW = (DEC_LAT < 1) ? 1 : $clog2(DEC_LAT + 1);

    sched_state_t     r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_first;
    logic             r_nar;
    logic [DW-1:0]    r_drain;
    logic             r_dec_vld;
    logic [WIDTH-1:0] r_dec_win;
    logic [WIDTH-1:0] r_dec_din;
    tag_t             r_tag;
    tag_t             w_tail;

    logic [1:0] w_w_cls;
    logic [1:0] w_d_cls;
    logic       w_xfer;
    logic       w_pair_nar;
    logic       w_pair_zero;
    logic       w_last;

    assign s_ready     = (r_state == RUN);
    assign w_xfer      = s_ready & s_w_valid & s_d_valid;
    assign w_w_cls     = classify(MAX_W'(s_w_data), WIDTH);
    assign w_d_cls     = classify(MAX_W'(s_d_data), WIDTH);
    assign w_pair_nar  = (w_w_cls == VLD_NAR) | (w_d_cls == VLD_NAR);
    // A NaR must reach the decoder even when its partner is zero.
    assign w_pair_zero = ((w_w_cls == VLD_ZERO) | (w_d_cls == VLD_ZERO)) & ~w_pair_nar;
    assign w_last      = (r_cnt == LEN_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_nar   <= 1'b0;
            r_drain <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_nar   <= 1'b0;
                        r_cnt   <= len;
                        r_first <= 1'b1;
                        r_state <= (len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_first <= 1'b0;
                        if (w_pair_nar)
                            r_nar <= 1'b1;
                        // Leaving RUN drops s_ready on the same edge, so the
                        // counter can never be pushed below zero.
                        if (w_last) begin
                            r_state <= DRAIN;
                            r_drain <= DW'(DEC_LAT);
                        end
                    end
                end
                DRAIN: begin
                    // Hold until the last tag has left the delay line.
                    if (r_drain == '0)
                        r_state <= DONE;
                    else
                        r_drain <= r_drain - 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_dec_vld <= 1'b0;
            r_dec_win <= '0;
            r_dec_din <= '0;
            r_tag     <= '0;
        end else begin
            r_dec_vld   <= w_xfer & ~w_pair_zero;
            // Skipped pairs leave the decoder inputs untouched to avoid toggling.
            if (w_xfer & ~w_pair_zero) begin
                r_dec_win <= s_w_data;
                r_dec_din <= s_d_data;
            end
            r_tag.slot  <= w_xfer;
            r_tag.skip  <= w_xfer & w_pair_zero;
            r_tag.first <= w_xfer & r_first;
            r_tag.last  <= w_xfer & w_last;
        end
    end

    posit_tag_pipe #(
        .DEPTH (DEC_LAT)
    ) u_tag_pipe (
        .clk_i (clk_i),
        .flush (rst),
        .tag_i (r_tag),
        .tag_o (w_tail)
    );

    assign dec_vld   = r_dec_vld;
    assign dec_win   = r_dec_win;
    assign dec_din   = r_dec_din;
    assign acc_en    = w_tail.slot & ~w_tail.skip;
    assign acc_skip  = w_tail.slot & w_tail.skip;
    assign acc_first = w_tail.slot & w_tail.first;
    assign acc_last  = w_tail.slot & w_tail.last;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign nar       = r_nar;

endmodule
